// File: rtl/accumulator_pkg.sv
// Shared definitions for the 4-bit burst accumulator: data and counter
// widths plus the FSM state encoding.
package accumulator_pkg;

  localparam int DATA_W = 4;  // operand / accumulator width
  localparam int CNT_W  = 4;  // op counter and carry counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/accumulator_4bit_if.sv
// Handshake bundle for accumulator_4bit.
//   start      : begins a burst (honoured only while idle)
//   in_valid   : operand beat present        in_ready  : beat accepted this cycle
//   A, Cin     : operand and carry-in
//   out_valid  : result present              out_ready : consumer takes result
//   S          : low nibble of the total     CarryCnt  : upper nibble (carry count)
//   busy       : block is not idle
// master = operand producer / result consumer, slave = the accumulator.
interface accumulator_4bit_if;
  import accumulator_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] A;
  logic              Cin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] S;
  logic [CNT_W-1:0]  CarryCnt;
  logic              busy;

  modport master (
    output start, in_valid, A, Cin, out_ready,
    input  in_ready, out_valid, S, CarryCnt, busy
  );

  modport slave (
    input  start, in_valid, A, Cin, out_ready,
    output in_ready, out_valid, S, CarryCnt, busy
  );
endinterface

// File: rtl/accumulator_4bit_adder.sv
// FullAdder4bit: gate-level ripple-carry adder, S = A + B + Cin, with the
// carry out of the top bit on Cout.
//   A, B : operands      Cin  : carry in
//   S    : sum           Cout : carry out
module FullAdder4bit
  import accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Cin,
  output logic [DATA_W-1:0] S,
  output logic              Cout
);

  logic [DATA_W:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[DATA_W];

endmodule

// File: rtl/accumulator_4bit.sv
// accumulator_4bit: sums N_OPS operand beats (A + Cin each) per burst.
// The total is reported as CarryCnt*16 + S once out_valid rises, and is
// held until the consumer asserts out_ready.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : accumulator_4bit_if.slave (start, operand and result handshakes)
// Parameter N_OPS: operands per burst, legal range 1..15 (keeps CarryCnt
// from wrapping, so no saturation is needed).
module accumulator_4bit
  import accumulator_pkg::*;
#(
  parameter int N_OPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  accumulator_4bit_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(N_OPS - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  carry_cnt;
  logic [CNT_W-1:0]  op_cnt;
  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              accept;
  logic              clear;

  // The only adder on the data path.
  FullAdder4bit u_adder (
    .A    (acc),
    .B    (bus.A),
    .Cin  (bus.Cin),
    .S    (sum),
    .Cout (cout)
  );

  // in_ready comes from registered state alone, so accept has no
  // combinational loop back through the producer.
  assign accept = bus.in_valid && (state == LOAD);
  assign clear  = bus.start && (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    if (accept && (op_cnt == LAST_OP)) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, carry counter and op counter. They move together only on
  // an accepted beat; in HOLD nothing changes, so the result stays stable
  // under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      carry_cnt <= '0;
      op_cnt    <= '0;
    end else if (clear) begin
      acc       <= '0;
      carry_cnt <= '0;
      op_cnt    <= '0;
    end else if (accept) begin
      acc       <= sum;
      carry_cnt <= carry_cnt + {{(CNT_W-1){1'b0}}, cout};
      op_cnt    <= op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);
  // The running value is always visible; out_valid qualifies it.
  assign bus.S         = acc;
  assign bus.CarryCnt  = carry_cnt;

endmodule

// File: tb/tb_accumulator_4bit.sv
// Directed bench for accumulator_4bit (N_OPS = 4). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_accumulator_4bit;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  accumulator_4bit_if bus ();

  accumulator_4bit #(.N_OPS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: each begins and ends on a falling edge.
  task automatic beat(input logic [3:0] a, input logic c);
    bus.A = a; bus.Cin = c; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.in_valid = 0; bus.A = 0; bus.Cin = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b0)  begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.S !== 4'd0)         begin miscompares++; $display("FAIL reset_S got %0d want 0", bus.S); end
    vectors++; if (bus.CarryCnt !== 4'd0)  begin miscompares++; $display("FAIL reset_CarryCnt got %0d want 0", bus.CarryCnt); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0)      begin miscompares++; $display("FAIL idle_no_start busy got %b want 0", bus.busy); end
  endtask

  // (2,0),(5,0),(3,1),(1,0) -> 12, no carries.
  task automatic test_basic();
    pulse_start();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_load_in_ready got %b want 1", bus.in_ready); end
    vectors++; if (bus.busy !== 1'b1)     begin miscompares++; $display("FAIL basic_load_busy got %b want 1", bus.busy); end
    beat(4'd2, 1'b0); beat(4'd5, 1'b0); beat(4'd3, 1'b1);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.S !== 4'd11)        begin miscompares++; $display("FAIL basic_partial_S got %0d want 11", bus.S); end
    beat(4'd1, 1'b0);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b0)  begin miscompares++; $display("FAIL basic_hold_in_ready got %b want 0", bus.in_ready); end
    vectors++; if (bus.S !== 4'd12)        begin miscompares++; $display("FAIL basic_S got %0d want 12", bus.S); end
    vectors++; if (bus.CarryCnt !== 4'd0)  begin miscompares++; $display("FAIL basic_CarryCnt got %0d want 0", bus.CarryCnt); end
    handshake();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_after_hs_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.busy !== 1'b0)      begin miscompares++; $display("FAIL basic_after_hs_busy got %b want 0", bus.busy); end
  endtask

  // (15,0)x4 -> running S 15,14,13,12 and CarryCnt 0,1,2,3 (total 60).
  // Leaves the block in HOLD for the backpressure test.
  task automatic test_carry();
    logic [3:0] exp_s [4];
    logic [3:0] exp_c [4];
    exp_s = '{4'd15, 4'd14, 4'd13, 4'd12};
    exp_c = '{4'd0, 4'd1, 4'd2, 4'd3};
    pulse_start();
    vectors++; if (bus.S !== 4'd0) begin miscompares++; $display("FAIL carry_cleared_S got %0d want 0", bus.S); end
    for (int i = 0; i < 4; i++) begin
      beat(4'd15, 1'b0);
      vectors++; if (bus.S !== exp_s[i])        begin miscompares++; $display("FAIL carry_S[%0d] got %0d want %0d", i, bus.S, exp_s[i]); end
      vectors++; if (bus.CarryCnt !== exp_c[i]) begin miscompares++; $display("FAIL carry_CarryCnt[%0d] got %0d want %0d", i, bus.CarryCnt, exp_c[i]); end
    end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL carry_out_valid got %b want 1", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2) == 0;
      bus.A        = 4'(i * 3 + 1);
      bus.Cin      = (i % 2) == 1;
      bus.start    = (i % 2) == 0;
      @(negedge clk);
      vectors++; if (bus.S !== 4'd12)        begin miscompares++; $display("FAIL bp_S[%0d] got %0d want 12", i, bus.S); end
      vectors++; if (bus.CarryCnt !== 4'd3)  begin miscompares++; $display("FAIL bp_CarryCnt[%0d] got %0d want 3", i, bus.CarryCnt); end
      vectors++; if (bus.in_ready !== 1'b0)  begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, bus.out_valid); end
    end
    bus.in_valid = 0; bus.A = 0; bus.Cin = 0; bus.start = 0;
    handshake();
    vectors++; if (bus.busy !== 1'b0)      begin miscompares++; $display("FAIL bp_after_hs_busy got %b want 0", bus.busy); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_after_hs_out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_gaps();
    pulse_start();
    beat(4'd2, 1'b0); beat(4'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.A = 4'd9; bus.Cin = 1'b1;
      @(negedge clk);
      vectors++; if (bus.S !== 4'd7)        begin miscompares++; $display("FAIL gap_S[%0d] got %0d want 7", i, bus.S); end
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL gap_in_ready[%0d] got %b want 1", i, bus.in_ready); end
    end
    beat(4'd3, 1'b1);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL gap_early_out_valid got %b want 0", bus.out_valid); end
    beat(4'd1, 1'b0);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL gap_out_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.S !== 4'd12)        begin miscompares++; $display("FAIL gap_S got %0d want 12", bus.S); end
    vectors++; if (bus.CarryCnt !== 4'd0)  begin miscompares++; $display("FAIL gap_CarryCnt got %0d want 0", bus.CarryCnt); end
    handshake();
  endtask

  task automatic test_reset_mid_burst();
    pulse_start();
    beat(4'd9, 1'b0); beat(4'd9, 1'b1);  // S=3, CarryCnt=1
    rst = 1'b1;
    #1;
    vectors++; if (bus.S !== 4'd0)         begin miscompares++; $display("FAIL rst_mid_S got %0d want 0", bus.S); end
    vectors++; if (bus.CarryCnt !== 4'd0)  begin miscompares++; $display("FAIL rst_mid_CarryCnt got %0d want 0", bus.CarryCnt); end
    vectors++; if (bus.in_ready !== 1'b0)  begin miscompares++; $display("FAIL rst_mid_in_ready got %b want 0", bus.in_ready); end
    vectors++; if (bus.busy !== 1'b0)      begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out_valid got %b want 0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.A = 4'd4;  // must not be taken while idle
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_waits_busy got %b want 0", bus.busy); end
    vectors++; if (bus.S !== 4'd0)    begin miscompares++; $display("FAIL rst_waits_S got %0d want 0", bus.S); end
    pulse_start();
    beat(4'd2, 1'b0); beat(4'd5, 1'b0); beat(4'd3, 1'b1); beat(4'd1, 1'b0);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_fresh_out_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.S !== 4'd12)        begin miscompares++; $display("FAIL rst_fresh_S got %0d want 12", bus.S); end
    vectors++; if (bus.CarryCnt !== 4'd0)  begin miscompares++; $display("FAIL rst_fresh_CarryCnt got %0d want 0", bus.CarryCnt); end
    handshake();
  endtask

  task automatic test_start_ignored();
    pulse_start();
    beat(4'd2, 1'b0); beat(4'd5, 1'b0);
    pulse_start();  // in LOAD: must not clear
    vectors++; if (bus.S !== 4'd7)        begin miscompares++; $display("FAIL start_load_S got %0d want 7", bus.S); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL start_load_in_ready got %b want 1", bus.in_ready); end
    beat(4'd3, 1'b1);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL start_count_kept got out_valid %b want 0", bus.out_valid); end
    beat(4'd1, 1'b0);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL start_out_valid got %b want 1", bus.out_valid); end
    bus.start = 1'b1; bus.out_ready = 1'b1;  // start on the handshake edge
    @(negedge clk);
    bus.start = 1'b0; bus.out_ready = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL start_hs_busy got %b want 0", bus.busy); end
    repeat (3) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL start_stays_idle got busy %b want 0", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL start_stays_idle got in_ready %b want 0", bus.in_ready); end
    vectors++; if (bus.S !== 4'd12)       begin miscompares++; $display("FAIL start_no_clear_S got %0d want 12", bus.S); end
    pulse_start();
    vectors++; if (bus.S !== 4'd0)        begin miscompares++; $display("FAIL start_new_clear_S got %0d want 0", bus.S); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL start_new_in_ready got %b want 1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_gaps();
    test_reset_mid_burst();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
